// File: rtl/system_0_pio_pkg.sv
// Shared definitions for the system_0 PIO family.
// Holds the register word offsets and the default data / counter widths
// so every PIO block decodes the same map.
package system_0_pio_pkg;

  localparam int PIO_DATA_WIDTH = 18;
  localparam int PIO_CNT_WIDTH  = 24;

  // Word offsets on the 3-bit Avalon address bus; 6 and 7 are reserved.
  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_MASK     = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

endpackage

// File: rtl/system_0_led_pio_blink_timer.sv
// Blink timer: a down-counter that reloads from the period register and
// toggles the blink phase every period+1 cycles.
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   period        current BLINK_PERIOD value (0 disables blinking)
//   load          a BLINK_PERIOD write this cycle
//   load_value    value being written to BLINK_PERIOD
//   phase         current blink phase
module system_0_led_pio_blink_timer
  import system_0_pio_pkg::*;
#(
  parameter int CNT_WIDTH = PIO_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [CNT_WIDTH-1:0] period,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_value,
  output logic                 phase
);

  logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
  logic                 phase_reg, phase_next;

  // A period write wins over a coincident expiry; the counter starts from
  // the new value with phase cleared. The counter only ever decrements
  // from a nonzero value, so it can never wrap below zero.
  always_comb begin
    cnt_next   = cnt_reg;
    phase_next = phase_reg;
    if (load) begin
      cnt_next   = load_value;
      phase_next = 1'b0;
    end else if (period == '0) begin
      cnt_next   = '0;
      phase_next = 1'b0;
    end else if (cnt_reg == '0) begin
      cnt_next   = period;
      phase_next = ~phase_reg;
    end else begin
      cnt_next   = cnt_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg   <= '0;
      phase_reg <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      phase_reg <= phase_next;
    end
  end

  assign phase = phase_reg;

endmodule

// File: rtl/system_0_led_pio.sv
// LED PIO with blink support on an Avalon-MM slave.
// Registers: DATA, BLINK_MASK, BLINK_PERIOD (RW), STATUS (RO, bit0 phase),
// OUTSET / OUTCLEAR (WO bit set / clear of DATA).
// Ports:
//   clk, reset_n        clock and asynchronous active-low reset
//   chipselect, write_n Avalon select and active-low write strobe
//   address             word offset
//   writedata           write data (upper unused bits ignored)
//   readdata            registered, zero-extended read data
//   out_port            registered LED drive: DATA ^ (MASK & phase)
module system_0_led_pio
  import system_0_pio_pkg::*;
#(
  parameter int                    DATA_WIDTH  = PIO_DATA_WIDTH,
  parameter int                    CNT_WIDTH   = PIO_CNT_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [2:0]            address,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);

  logic [DATA_WIDTH-1:0] data_reg, data_next;
  logic [DATA_WIDTH-1:0] mask_reg, mask_next;
  logic [CNT_WIDTH-1:0]  period_reg, period_next;
  logic [31:0]           readdata_reg, readdata_next;
  logic [DATA_WIDTH-1:0] out_reg, out_next;
  logic                  wr_en;
  logic                  period_load;
  logic                  phase;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic [CNT_WIDTH-1:0]  wdata_c;
  logic                  unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign wdata_d      = writedata[DATA_WIDTH-1:0];
  assign wdata_c      = writedata[CNT_WIDTH-1:0];
  assign unused_wdata = ^writedata;

  // Register write decode; STATUS and the reserved offsets fall through.
  always_comb begin
    data_next   = data_reg;
    mask_next   = mask_reg;
    period_next = period_reg;
    period_load = 1'b0;
    if (wr_en) begin
      case (address)
        ADDR_DATA:     data_next = wdata_d;
        ADDR_MASK:     mask_next = wdata_d;
        ADDR_PERIOD: begin
          period_next = wdata_c;
          period_load = 1'b1;
        end
        ADDR_OUTSET:   data_next = data_reg | wdata_d;
        ADDR_OUTCLEAR: data_next = data_reg & ~wdata_d;
        default:       ;
      endcase
    end
  end

  // Read mux is not gated by chipselect; write-only and reserved read 0.
  always_comb begin
    readdata_next = '0;
    case (address)
      ADDR_DATA:   readdata_next = 32'(data_reg);
      ADDR_MASK:   readdata_next = 32'(mask_reg);
      ADDR_PERIOD: readdata_next = 32'(period_reg);
      ADDR_STATUS: readdata_next = {31'b0, phase};
      default:     readdata_next = '0;
    endcase
  end

  assign out_next = data_reg ^ (mask_reg & {DATA_WIDTH{phase}});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg     <= RESET_VALUE;
      mask_reg     <= '0;
      period_reg   <= '0;
      readdata_reg <= '0;
      out_reg      <= RESET_VALUE;
    end else begin
      data_reg     <= data_next;
      mask_reg     <= mask_next;
      period_reg   <= period_next;
      readdata_reg <= readdata_next;
      out_reg      <= out_next;
    end
  end

  system_0_led_pio_blink_timer #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_blink_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .period     (period_reg),
    .load       (period_load),
    .load_value (wdata_c),
    .phase      (phase)
  );

  assign readdata = readdata_reg;
  assign out_port = out_reg;

endmodule

// File: tb/tb_system_0_led_pio.sv
// Directed plus randomized bench for system_0_led_pio. The reference model
// tracks register contents and the number of cycles since the last period
// write; the phase is derived from that elapsed time arithmetically.
module tb_system_0_led_pio;

  localparam int              DW = 18;
  localparam int              CW = 24;
  localparam logic [DW-1:0]   RV = 18'h01234;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          chipselect;
  logic          write_n;
  logic [2:0]    address;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [DW-1:0] out_port;

  always #5 clk = ~clk;

  system_0_led_pio #(
    .DATA_WIDTH  (DW),
    .CNT_WIDTH   (CW),
    .RESET_VALUE (RV)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .chipselect (chipselect),
    .write_n    (write_n),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  // Reference model state
  logic [DW-1:0] m_data;
  logic [DW-1:0] m_mask;
  logic [CW-1:0] m_period;
  longint        m_elapsed;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic model_reset();
    m_data    = RV;
    m_mask    = '0;
    m_period  = '0;
    m_elapsed = 0;
  endtask

  // Phase holds for period+1 cycles, then flips; zero period means off.
  function automatic logic m_phase();
    if (m_period == '0) return 1'b0;
    return ((m_elapsed / (longint'(m_period) + 1)) % 2) == 1;
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return 32'(m_data);
      3'd1:    return 32'(m_mask);
      3'd2:    return 32'(m_period);
      3'd3:    return {31'b0, m_phase()};
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive, predict, clock, compare.
  task automatic step(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] wd);
    logic [31:0]   exp_rd;
    logic [DW-1:0] exp_out;
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = wd;
    exp_rd  = m_read(a);
    exp_out = m_data ^ (m_mask & {DW{m_phase()}});
    if (m_period != '0) m_elapsed++;
    if (cs && !wn) begin
      case (a)
        3'd0: m_data = wd[DW-1:0];
        3'd1: m_mask = wd[DW-1:0];
        3'd2: begin
          m_period  = wd[CW-1:0];
          m_elapsed = 0;
        end
        3'd4: m_data = m_data | wd[DW-1:0];
        3'd5: m_data = m_data & ~wd[DW-1:0];
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    $display("t=%0t cs=%0b wn=%0b a=%0d wd=%h rd=%h out=%h", $time, cs, wn, a, wd, readdata, out_port);
    check("readdata", readdata, exp_rd);
    check("out_port", 32'(out_port), 32'(exp_out));
  endtask

  initial begin
    logic [2:0]  ra;
    logic [31:0] rwd;
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = '0;
    writedata  = '0;
    model_reset();
    #12;
    check("rst_out", 32'(out_port), 32'(RV));
    check("rst_rd", readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // DATA write with junk upper bits, then read back
    step(1, 0, 3'd0, 32'hABC2_A5A5);
    step(0, 1, 3'd0, 32'h0);
    check("data_out", 32'(out_port), 32'h0002_A5A5);
    check("data_rd", readdata, 32'h0002_A5A5);

    // OUTSET / OUTCLEAR
    step(1, 0, 3'd0, 32'h0000_0F0F);
    step(1, 0, 3'd4, 32'h0000_00F0);
    step(1, 0, 3'd5, 32'h0000_0F00);
    step(1, 1, 3'd0, 32'h0);
    check("setclr_rd", readdata, 32'h0000_00FF);
    step(1, 1, 3'd4, 32'h0);
    check("rd_off4", readdata, 32'h0);
    step(1, 1, 3'd5, 32'h0);
    check("rd_off5", readdata, 32'h0);

    // Blink DATA=0 MASK=3 PERIOD=3, watch STATUS
    step(1, 0, 3'd0, 32'h0);
    step(1, 0, 3'd1, 32'h3);
    step(1, 0, 3'd2, 32'h3);
    for (int i = 0; i < 20; i++) step(0, 1, 3'd3, 32'h0);

    // Disable blinking mid-phase
    step(1, 0, 3'd2, 32'h0);
    for (int i = 0; i < 8; i++) step(0, 1, 3'd3, 32'h0);
    check("off_out", 32'(out_port), 32'h0);

    // Period write landing exactly on the expiry cycle
    step(1, 0, 3'd2, 32'h3);
    for (int i = 0; i < 3; i++) step(0, 1, 3'd3, 32'h0);
    step(1, 0, 3'd2, 32'h3);
    for (int i = 0; i < 10; i++) step(0, 1, 3'd3, 32'h0);

    // Ignored writes
    step(0, 0, 3'd0, 32'h3FFFF);
    step(1, 1, 3'd0, 32'h3FFFF);
    step(1, 0, 3'd3, 32'hFFFF_FFFF);
    step(1, 0, 3'd6, 32'hFFFF_FFFF);
    step(1, 0, 3'd7, 32'hFFFF_FFFF);
    step(0, 1, 3'd0, 32'h0);
    step(0, 1, 3'd1, 32'h0);
    step(0, 1, 3'd2, 32'h0);

    // Asynchronous reset mid-blink
    step(1, 0, 3'd0, 32'h0_0550);
    step(1, 0, 3'd1, 32'h3_000F);
    step(1, 0, 3'd2, 32'h2);
    for (int i = 0; i < 5; i++) step(0, 1, 3'd0, 32'h0);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_out", 32'(out_port), 32'(RV));
    check("async_rd", readdata, 32'h0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) step(0, 1, 3'd3, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      ra  = 3'($urandom_range(0, 7));
      rwd = $urandom;
      if (ra == 3'd2)
        rwd = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 5));
      step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), ra, rwd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/system_0_led_pio.md
SYSTEM_0_LED_PIO -- requirements
Module: system_0_led_pio

Interface
REQ-001 Parameter DATA_WIDTH, default 18, SHALL set the width of out_port and of the data and mask registers.
REQ-002 Parameter CNT_WIDTH, default 24, SHALL set the width of the blink period register and counter.
REQ-003 Parameter RESET_VALUE, default 0, SHALL be the data register value after reset.
REQ-004 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 chipselect  in  1  Avalon slave select.
REQ-007 write_n  in  1  active-low write strobe, qualified by chipselect.
REQ-008 address  in  3  word register offset.
REQ-009 writedata  in  32  write data; bits above the register width SHALL be ignored.
REQ-010 readdata  out  32  registered read data, zero-extended.
REQ-011 out_port  out  DATA_WIDTH  registered LED drive.

Function
REQ-012 Write SHALL occur on a cycle with chipselect=1 and write_n=0; at most one register is written per cycle.
REQ-013 Register map: 0 DATA (RW), 1 BLINK_MASK (RW), 2 BLINK_PERIOD (RW), 3 STATUS (RO, bit0 = phase), 4 OUTSET (WO), 5 OUTCLEAR (WO), 6-7 reserved.
REQ-014 Write to OUTSET SHALL perform DATA <= DATA | writedata; write to OUTCLEAR SHALL perform DATA <= DATA & ~writedata.
REQ-015 Writes to STATUS, 6 and 7 SHALL have no effect.
REQ-016 readdata SHALL equal the selected register, zero-extended, one cycle after address is presented, independent of chipselect; offsets 4-7 SHALL read 0.
REQ-017 Blink counter SHALL decrement every cycle while BLINK_PERIOD != 0; on reaching 0 it SHALL reload BLINK_PERIOD and toggle phase in the same cycle, giving a phase half-period of BLINK_PERIOD+1 cycles.
REQ-018 When BLINK_PERIOD = 0, counter SHALL hold 0 and phase SHALL be forced 0.
REQ-019 A write to BLINK_PERIOD SHALL load the counter with the new value and clear phase; this SHALL take priority over a coincident counter expiry.
REQ-020 out_port SHALL equal, one cycle after any state change, DATA XOR (BLINK_MASK AND {DATA_WIDTH{phase}}).
REQ-021 A write to DATA coinciding with a phase toggle SHALL both take effect; out_port the next cycle SHALL reflect the new DATA and the new phase.
REQ-022 Counter arithmetic SHALL be unsigned CNT_WIDTH; no wrap below 0 SHALL occur.

Reset
REQ-023 While reset_n=0: DATA=RESET_VALUE, BLINK_MASK=0, BLINK_PERIOD=0, counter=0, phase=0, readdata=0, out_port=RESET_VALUE.
REQ-024 Reset asserted mid-blink SHALL take effect immediately without waiting for clk; after release the block SHALL be idle with blinking disabled.

Structure
REQ-025 Register offsets (0-5) and default widths SHALL live in a shared package system_0_pio_pkg used by all PIO blocks.
REQ-026 Counter, reload and phase logic SHALL be one sub-module system_0_led_pio_blink_timer with inputs period, load, and output phase.

Verification
REQ-027 Reset, then write DATA=0x2A5A5 -> out_port=0x2A5A5 next cycle; read offset 0 -> readdata=0x0002A5A5.
REQ-028 DATA=0x00F0F, OUTSET 0x000F0 then OUTCLEAR 0x00F00 -> DATA reads 0x000FF; offsets 4/5 read 0.
REQ-029 DATA=0, MASK=0x00003, PERIOD=3 -> out_port toggles between 0x00000 and 0x00003 every 4 cycles; STATUS bit0 tracks phase.
REQ-030 During blinking, write PERIOD=0 -> phase=0, out_port=DATA next cycle and stays; writing PERIOD on the expiry cycle -> counter reloaded, phase=0 (no toggle).
REQ-031 Assert reset_n=0 between clock edges mid-blink -> out_port=RESET_VALUE and readdata=0 immediately; after release no toggling.
REQ-032 Write with chipselect=0 or write_n=1, and writes to offsets 3/6/7 -> no register changes.
